// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button front end and run/pause/lap/clear control FSM
// Buttons are synchronized and debounced on the 100 Hz tick; the FSM is clocked every clk.
module stopwatch_ctrl #(
  parameter int DEB_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_100hz,
  input  logic       i_btn_start,
  input  logic       i_btn_lap,
  input  logic       i_btn_clr,
  input  logic [7:0] i_time_min,
  input  logic [7:0] i_time_sec,
  input  logic [7:0] i_time_cs,
  output logic       o_run,
  output logic       o_clr,
  output logic       o_disp_sel,
  output logic [7:0] o_lap_min,
  output logic [7:0] o_lap_sec,
  output logic [7:0] o_lap_cs,
  output logic [3:0] o_lap_cnt,
  output logic [1:0] o_state
);

  localparam int CW = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  // Button index: 0 = start, 1 = lap, 2 = clr.
  logic [2:0]    w_btn;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_evt;
  logic [CW-1:0] r_cnt [3];

  logic w_ev_start;
  logic w_ev_clr;
  logic w_ev_lap;

  state_t     r_state;
  logic       r_run;
  logic       r_clr;
  logic       r_disp_sel;
  logic [7:0] r_lap_min;
  logic [7:0] r_lap_sec;
  logic [7:0] r_lap_cs;
  logic [3:0] r_lap_cnt;

  assign w_btn = {i_btn_clr, i_btn_lap, i_btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_deb   <= 3'b000;
      r_evt   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (i_tick_100hz) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
            // Only the rising debounced edge is a press; release is silent.
            r_evt[i] <= r_sync2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // One event per clk reaches the FSM: start beats clr beats lap.
  assign w_ev_start = r_evt[0];
  assign w_ev_clr   = r_evt[2] & ~r_evt[0];
  assign w_ev_lap   = r_evt[1] & ~r_evt[0] & ~r_evt[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_clr      <= 1'b0;
      r_disp_sel <= 1'b0;
      r_lap_min  <= 8'd0;
      r_lap_sec  <= 8'd0;
      r_lap_cs   <= 8'd0;
      r_lap_cnt  <= 4'd0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ev_start) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end else if (w_ev_clr) begin
            r_clr <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_ev_start) begin
            r_state <= S_PAUSE;
            r_run   <= 1'b0;
          end else if (w_ev_lap) begin
            r_state    <= S_LAP;
            r_disp_sel <= 1'b1;
            r_lap_min  <= i_time_min;
            r_lap_sec  <= i_time_sec;
            r_lap_cs   <= i_time_cs;
            if (r_lap_cnt != 4'd15) r_lap_cnt <= r_lap_cnt + 4'd1;
          end
        end
        S_LAP: begin
          if (w_ev_start) begin
            r_state    <= S_PAUSE;
            r_run      <= 1'b0;
            r_disp_sel <= 1'b0;
          end else if (w_ev_clr) begin
            r_state    <= S_RUN;
            r_disp_sel <= 1'b0;
          end else if (w_ev_lap) begin
            r_lap_min <= i_time_min;
            r_lap_sec <= i_time_sec;
            r_lap_cs  <= i_time_cs;
            if (r_lap_cnt != 4'd15) r_lap_cnt <= r_lap_cnt + 4'd1;
          end
        end
        S_PAUSE: begin
          if (w_ev_start) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end else if (w_ev_clr) begin
            r_state   <= S_IDLE;
            r_clr     <= 1'b1;
            r_lap_min <= 8'd0;
            r_lap_sec <= 8'd0;
            r_lap_cs  <= 8'd0;
            r_lap_cnt <= 4'd0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_run      <= 1'b0;
          r_disp_sel <= 1'b0;
        end
      endcase
    end
  end

  assign o_run      = r_run;
  assign o_clr      = r_clr;
  assign o_disp_sel = r_disp_sel;
  assign o_lap_min  = r_lap_min;
  assign o_lap_sec  = r_lap_sec;
  assign o_lap_cs   = r_lap_cs;
  assign o_lap_cnt  = r_lap_cnt;
  assign o_state    = r_state;

endmodule
